// File: rtl/norm_shift_64.sv
`default_nettype none
// ============================================================================
//  Module      : norm_shift_64
//  Description : Two-stage normalization shifter. Left-shifts a 64-bit
//                mantissa by its leading-zero count, adjusts the biased
//                exponent, and clamps at the denormal boundary. Valid/ready
//                handshake on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module norm_shift_64 #(
    parameter int EXP_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_mant,
    input  logic [6:0]       in_lzc,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_denorm
);

    // Comparison width: wide enough for both the exponent and the 7-bit count
    localparam int c_cw = (EXP_W > 7) ? EXP_W : 7;

    // Stage 1 state
    logic             r_s1_valid;
    logic [63:0]      r_s1_mant;
    logic [2:0]       r_s1_fine;
    logic [EXP_W-1:0] r_s1_exp;
    logic             r_s1_zero;
    logic             r_s1_denorm;

    // Stage 2 (output) state
    logic             r_s2_valid;
    logic [63:0]      r_out_mant;
    logic [EXP_W-1:0] r_out_exp;
    logic             r_out_zero;
    logic             r_out_denorm;

    // Combinational shift decision
    logic [c_cw-1:0]  w_exp_x;
    logic [c_cw-1:0]  w_lzc_x;
    logic             w_zero;
    logic             w_denorm;
    logic [5:0]       w_sh;
    logic [EXP_W-1:0] w_exp_new;
    logic [63:0]      w_coarse;
    logic             w_s1_adv;
    logic             w_in_ready;

    assign w_exp_x = c_cw'(in_exp);
    assign w_lzc_x = c_cw'(in_lzc);

    // Any count with bit 6 set (64..127) means an all-zero mantissa
    assign w_zero = in_lzc[6];

    // Pick the shift amount and new exponent; the shift never exceeds the
    // leading-zero count, so no set mantissa bit is ever shifted out
    always_comb begin
        w_sh      = 6'd0;
        w_exp_new = '0;
        w_denorm  = 1'b0;
        if (w_zero) begin
            w_sh      = 6'd0;
        end else if (w_exp_x > w_lzc_x) begin
            w_sh      = in_lzc[5:0];
            w_exp_new = in_exp - EXP_W'(in_lzc);
        end else if (in_exp == '0) begin
            w_denorm  = 1'b1;
        end else begin
            // Here 1 <= in_exp <= in_lzc <= 63, so the low six bits suffice
            w_sh      = in_exp[5:0] - 6'd1;
            w_denorm  = 1'b1;
        end
    end

    // Coarse byte-granular shift happens in stage 1, the 0..7 remainder in stage 2
    assign w_coarse = w_zero ? 64'd0 : (in_mant << {w_sh[5:3], 3'b000});

    assign w_s1_adv   = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s1_adv;
    assign in_ready   = w_in_ready;

    // Stage 1: capture an accepted beat with the coarse shift applied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_mant   <= 64'd0;
            r_s1_fine   <= 3'd0;
            r_s1_exp    <= '0;
            r_s1_zero   <= 1'b0;
            r_s1_denorm <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mant   <= w_coarse;
                r_s1_fine   <= w_sh[2:0];
                r_s1_exp    <= w_exp_new;
                r_s1_zero   <= w_zero;
                r_s1_denorm <= w_denorm;
            end
        end
    end

    // Stage 2: apply the fine shift into the output registers when allowed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_out_mant   <= 64'd0;
            r_out_exp    <= '0;
            r_out_zero   <= 1'b0;
            r_out_denorm <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_mant   <= r_s1_mant << r_s1_fine;
                r_out_exp    <= r_s1_exp;
                r_out_zero   <= r_s1_zero;
                r_out_denorm <= r_s1_denorm;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_mant   = r_out_mant;
    assign out_exp    = r_out_exp;
    assign out_zero   = r_out_zero;
    assign out_denorm = r_out_denorm;

endmodule
`default_nettype wire

// File: tb/tb_norm_shift_64.sv
`default_nettype none
// ============================================================================
//  Module      : tb_norm_shift_64
//  Description : Directed, table-driven bench for norm_shift_64.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_norm_shift_64;

    localparam int EXP_W = 11;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_mant;
    logic [6:0]       in_lzc;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_mant;
    logic [EXP_W-1:0] out_exp;
    logic             out_zero;
    logic             out_denorm;

    norm_shift_64 #(.EXP_W(EXP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_lzc     (in_lzc),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_zero   (out_zero),
        .out_denorm (out_denorm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]      mant;
        logic [6:0]       lzc;
        logic [EXP_W-1:0] exp;
        logic [63:0]      emant;
        logic [EXP_W-1:0] eexp;
        logic             ezero;
        logic             edenorm;
    } vec_t;

    vec_t vecs [12];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic chk_out(input int i, input string tag);
        chk($sformatf("%s v%0d mant", tag, i), out_mant, vecs[i].emant);
        chk($sformatf("%s v%0d exp", tag, i), 64'(out_exp), 64'(vecs[i].eexp));
        chk($sformatf("%s v%0d zero", tag, i), 64'(out_zero), 64'(vecs[i].ezero));
        chk($sformatf("%s v%0d denorm", tag, i), 64'(out_denorm), 64'(vecs[i].edenorm));
    endtask

    task automatic drive(input int i);
        in_mant = vecs[i].mant;
        in_lzc  = vecs[i].lzc;
        in_exp  = vecs[i].exp;
    endtask

    // Single beat through an idle pipe, checking the 2-cycle latency
    task automatic run_vec(input int i);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(i);
        #1;
        chk($sformatf("v%0d in_ready idle", i), 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d out_valid early", i), 64'(out_valid), 64'd0);
        @(negedge clk);
        chk($sformatf("v%0d out_valid at latency 2", i), 64'(out_valid), 64'd1);
        chk_out(i, "single");
    endtask

    // Stream n vectors back to back; out_ready low for the first 'stall' cycles
    task automatic stream(input int first, input int n, input int stall);
        int          acc;
        int          rcv;
        logic        prev_stall;
        logic [63:0] pm;
        logic [EXP_W-1:0] pe;
        acc = 0;
        rcv = 0;
        prev_stall = 1'b0;
        pm = '0;
        pe = '0;
        for (int cyc = 0; cyc < 60 && rcv < n; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= stall);
            in_valid  = (acc < n);
            if (acc < n) drive(first + acc);
            #1;
            if (prev_stall) begin
                chk("stall out_valid held", 64'(out_valid), 64'd1);
                chk("stall out_mant stable", out_mant, pm);
                chk("stall out_exp stable", 64'(out_exp), 64'(pe));
            end
            prev_stall = out_valid && !out_ready;
            pm = out_mant;
            pe = out_exp;
            if (out_valid && out_ready) begin
                chk_out(first + rcv, "stream");
                rcv++;
            end
            if (stall > 0 && acc == 2 && !out_ready)
                chk("bp in_ready low with 2 held", 64'(in_ready), 64'd0);
            if (stall == 0 && acc < n)
                chk("tput in_ready high", 64'(in_ready), 64'd1);
            if (in_valid && in_ready) acc++;
        end
        chk("stream beats delivered", 64'(rcv), 64'(n));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{64'h0000_0000_0001_0000, 7'd47,  11'd100,  64'h8000_0000_0000_0000, 11'd53,   1'b0, 1'b0};
        vecs[1]  = '{64'h0000_0000_0000_00FF, 7'd56,  11'd10,   64'h0000_0000_0001_FE00, 11'd0,    1'b0, 1'b1};
        vecs[2]  = '{64'h00FF_0000_0000_0000, 7'd8,   11'd8,    64'h7F80_0000_0000_0000, 11'd0,    1'b0, 1'b1};
        vecs[3]  = '{64'h0,                   7'd64,  11'd500,  64'h0,                   11'd0,    1'b1, 1'b0};
        vecs[4]  = '{64'h0,                   7'd100, 11'd3,    64'h0,                   11'd0,    1'b1, 1'b0};
        vecs[5]  = '{64'h8000_0000_0000_0000, 7'd0,   11'd1,    64'h8000_0000_0000_0000, 11'd1,    1'b0, 1'b0};
        vecs[6]  = '{64'h0400_0000_0000_0000, 7'd5,   11'd0,    64'h0400_0000_0000_0000, 11'd0,    1'b0, 1'b1};
        vecs[7]  = '{64'h0000_0000_0000_0001, 7'd63,  11'd2047, 64'h8000_0000_0000_0000, 11'd1984, 1'b0, 1'b0};
        vecs[8]  = '{64'h0000_0000_0000_0001, 7'd63,  11'd64,   64'h8000_0000_0000_0000, 11'd1,    1'b0, 1'b0};
        vecs[9]  = '{64'h0000_0000_0000_0001, 7'd63,  11'd63,   64'h4000_0000_0000_0000, 11'd0,    1'b0, 1'b1};
        vecs[10] = '{64'h0000_1234_5678_9ABC, 7'd19,  11'd30,   64'h91A2_B3C4_D5E0_0000, 11'd11,   1'b0, 1'b0};
        vecs[11] = '{64'h0000_0000_00FF_FFFF, 7'd40,  11'd5,    64'h0000_0000_0FFF_FFF0, 11'd0,    1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_mant   = '0;
        in_lzc    = '0;
        in_exp    = '0;

        // Reset state
        #3;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_mant", out_mant, 64'd0);
        chk("reset out_exp", 64'(out_exp), 64'd0);
        chk("reset out_zero", 64'(out_zero), 64'd0);
        chk("reset out_denorm", 64'(out_denorm), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("in_ready after reset", 64'(in_ready), 64'd1);

        // Table: each vector alone through the pipe
        for (int i = 0; i < 12; i++) run_vec(i);

        // Full-rate streaming of the whole table
        stream(0, 12, 0);

        // Back-pressure: 4 beats, out_ready low for 5 cycles
        stream(0, 4, 5);

        // Reset with two beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(7);
        @(negedge clk);
        drive(8);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("inflight out_valid before reset", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("out_valid drops with async reset", 64'(out_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("no stale beat after reset", 64'(out_valid), 64'd0);
        end
        chk("in_ready after mid-flight reset", 64'(in_ready), 64'd1);
        run_vec(10);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
